mem_access_sequencer: RTL and testbench

MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

---
 rtl/mips_pkg.sv | 20 ++
 rtl/mem_access_sequencer.sv | 114 +++++++++++
 tb/tb_mem_access_sequencer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS datapath: memory sequencer states,
// default memory latency and instruction field positions.
package mips_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RD_WAIT    = 3'd1,
        RD_CAPTURE = 3'd2,
        WR_PULSE   = 3'd3,
        DONE       = 3'd4
    } mem_state_e;

    localparam int MEM_LATENCY_DEFAULT = 2;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;

endpackage

// File: rtl/mem_access_sequencer.sv
// Sequences one memory read or write at a time for the multicycle datapath,
// capturing read data into either the instruction register or the memory data register.
module mem_access_sequencer
    import mips_pkg::*;
#(
    parameter int MEM_LATENCY = MEM_LATENCY_DEFAULT
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        req_we,
    input  logic        req_fetch,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr,
    output logic        busy,
    output logic        done,
    output logic [31:0] ir,
    output logic [31:0] mdr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct
);

    // The wait counter runs from MEM_LATENCY-1 down to 0, so RD_WAIT spans MEM_LATENCY cycles.
    localparam logic [2:0] WAIT_LOAD = 3'(MEM_LATENCY - 1);

    mem_state_e  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        fetch_q, fetch_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] mdr_q, mdr_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            fetch_q <= 1'b0;
            ir_q    <= 32'd0;
            mdr_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            fetch_q <= fetch_d;
            ir_q    <= ir_d;
            mdr_q   <= mdr_d;
        end
    end

    // Requests are only looked at in IDLE; everywhere else they are dropped, not queued.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        fetch_d = fetch_q;
        ir_d    = ir_q;
        mdr_d   = mdr_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    fetch_d = req_fetch;
                    if (req_we) begin
                        state_d = WR_PULSE;
                    end else begin
                        state_d = RD_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = RD_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RD_CAPTURE: begin
                if (fetch_q) begin
                    ir_d = mem_rdata;
                end else begin
                    mdr_d = mem_rdata;
                end
                state_d = DONE;
            end
            WR_PULSE: state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Strobes decode straight from the state register so reset clears them without waiting for an edge.
    assign mem_wr    = (state_q == WR_PULSE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign ir        = ir_q;
    assign mdr       = mdr_q;
    assign opcode    = ir_q[OPCODE_MSB:OPCODE_LSB];
    assign funct     = ir_q[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer: directed scenarios followed by
// randomized accesses compared against a transaction-level model of the block.
module tb_mem_access_sequencer;

    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        req_we = 1'b0;
    logic        req_fetch = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [31:0] mem_rdata = 32'd0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr;
    logic        busy;
    logic        done;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic [5:0]  opcode;
    logic [5:0]  funct;

    int checkCount = 0;
    int errorCount = 0;

    logic [31:0] expIr = 32'd0;
    logic [31:0] expMdr = 32'd0;
    logic [31:0] expAddr = 32'd0;
    logic [31:0] expWdata = 32'd0;

    mem_access_sequencer #(.MEM_LATENCY(LAT)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .req_we    (req_we),
        .req_fetch (req_fetch),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wr    (mem_wr),
        .busy      (busy),
        .done      (done),
        .ir        (ir),
        .mdr       (mdr),
        .opcode    (opcode),
        .funct     (funct)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Everything the block should show while sitting idle, derived from the model.
    task automatic checkIdle(input string tag);
        checkOutput({tag, " busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, " done"}, {31'd0, done}, 32'd0);
        checkOutput({tag, " mem_wr"}, {31'd0, mem_wr}, 32'd0);
        checkOutput({tag, " mem_addr"}, mem_addr, expAddr);
        checkOutput({tag, " mem_wdata"}, mem_wdata, expWdata);
        checkOutput({tag, " ir"}, ir, expIr);
        checkOutput({tag, " mdr"}, mdr, expMdr);
        checkOutput({tag, " opcode"}, {26'd0, opcode}, expIr >> 26);
        checkOutput({tag, " funct"}, {26'd0, funct}, expIr % 64);
    endtask

    // One access from request to return-to-idle. A read is busy for LAT+2 cycles
    // (wait, capture, done) and must sample memory only in its capture cycle; a write
    // is busy for 2 cycles with the strobe in the first. noise scribbles on the request
    // inputs while busy, which must all be ignored.
    task automatic applyStimulus(input string tag, input logic we, input logic fetch,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input logic noise);
        int expLen;
        expLen    = we ? 2 : LAT + 2;
        req       = 1'b1;
        req_we    = we;
        req_fetch = fetch;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clock);
        #1;
        expAddr  = addr;
        expWdata = wdata;
        for (int k = 1; k <= expLen; k++) begin
            mem_rdata = (!we && k == expLen - 1) ? rdata : $urandom;
            if (noise) begin
                req       = 1'($urandom_range(0, 1));
                req_we    = 1'($urandom_range(0, 1));
                req_fetch = 1'($urandom_range(0, 1));
                req_addr  = $urandom;
                req_wdata = $urandom;
            end else begin
                req = 1'b0;
            end
            @(negedge clock);
            checkOutput({tag, " busy"}, {31'd0, busy}, 32'd1);
            checkOutput({tag, " done"}, {31'd0, done}, {31'd0, k == expLen});
            checkOutput({tag, " mem_wr"}, {31'd0, mem_wr}, {31'd0, we && k == 1});
            checkOutput({tag, " mem_addr"}, mem_addr, expAddr);
            checkOutput({tag, " mem_wdata"}, mem_wdata, expWdata);
            @(posedge clock);
            #1;
        end
        req = 1'b0;
        mem_rdata = $urandom;
        if (!we) begin
            if (fetch) expIr = rdata;
            else       expMdr = rdata;
        end
        checkIdle({tag, " end"});
    endtask

    // Reset in the middle of an access must kill it outright with no capture or done.
    task automatic applyResetMidAccess(input string tag, input logic we, input int cyclesIn);
        req       = 1'b1;
        req_we    = we;
        req_fetch = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        mem_rdata = $urandom;
        @(posedge clock);
        #1;
        req = 1'b0;
        for (int k = 1; k < cyclesIn; k++) begin
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        checkOutput({tag, " busy before reset"}, {31'd0, busy}, 32'd1);
        checkOutput({tag, " mem_wr before reset"}, {31'd0, mem_wr}, {31'd0, we});
        #2;
        reset = 1'b1;
        #1;
        expIr = 32'd0; expMdr = 32'd0; expAddr = 32'd0; expWdata = 32'd0;
        checkIdle({tag, " in reset"});
        @(posedge clock);
        #1;
        checkIdle({tag, " held"});
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < LAT + 3; k++) begin
            @(negedge clock);
            checkIdle({tag, " after release"});
        end
    endtask

    initial begin
        $display("[TB] start, MEM_LATENCY=%0d", LAT);
        #3;
        checkIdle("reset");
        @(negedge clock);
        reset = 1'b0;
        checkIdle("released");

        applyStimulus("fetch", 1'b0, 1'b1, 32'h0000_0004, 32'h0, 32'h8C22_0008, 1'b0);
        checkOutput("fetch opcode", {26'd0, opcode}, 32'h23);
        applyStimulus("dread", 1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
        applyStimulus("write", 1'b1, 1'b0, 32'h0000_0020, 32'h1234_5678, 32'h0, 1'b0);
        applyStimulus("write fetchbit", 1'b1, 1'b1, 32'h0000_0024, 32'hCAFE_F00D, 32'h0, 1'b0);
        applyStimulus("read noisy", 1'b0, 1'b0, 32'h0000_0030, 32'h0, 32'hA5A5_5A5A, 1'b1);
        applyStimulus("b2b fetch", 1'b0, 1'b1, 32'h0000_0040, 32'h0, 32'h0000_0020, 1'b1);
        applyStimulus("b2b write", 1'b1, 1'b0, 32'h0000_0044, 32'h0BAD_CAFE, 32'h0, 1'b1);

        applyResetMidAccess("rst in write", 1'b1, 1);
        applyStimulus("after rst", 1'b0, 1'b1, 32'h0000_0008, 32'h0, 32'h2108_0020, 1'b0);
        applyResetMidAccess("rst in read", 1'b0, 2);

        for (int n = 0; n < 40; n++) begin
            applyStimulus("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                @(negedge clock);
                checkIdle("gap");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
